// File: rtl/wb_commit_queue_pkg.sv
// Shared types and constants for the writeback/commit queue.
// Optional feature macro: WB_RETIRE_CNT_EN (adds a 64-bit retire counter).
package wb_commit_queue_pkg;

  // Writeback control bundle carried in the MEM/WB register
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic [1:0] ld_size;
    logic       ld_signed;
  } struct_wb_ext;

  // Load size encodings
  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;

  // Number of significant load bits; a doubleword on a 32-bit datapath is a word
  function automatic int unsigned ld_bits(input logic [1:0] ld_size, input int unsigned data_w);
    int unsigned bits;
    case (ld_size)
      LD_B:    bits = 8;
      LD_H:    bits = 16;
      LD_W:    bits = 32;
      default: bits = data_w;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/wb_load_extend.sv
// Combinational load-data size selection and sign/zero extension.
module wb_load_extend
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] aligned;
  int unsigned       shamt;

  // Left-justify the loaded field, then shift back arithmetically or logically
  always_comb begin
    shamt   = DATA_W - ld_bits(ld_size, DATA_W);
    aligned = raw << shamt;
    if (ld_signed) begin
      ext = $unsigned($signed(aligned) >>> shamt);
    end else begin
      ext = aligned >> shamt;
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Writeback/commit stage: value select, pending-write FIFO toward the register
// file, and a youngest-first bypass lookup for ID.
// Optional feature macro: WB_RETIRE_CNT_EN (64-bit count of accepted instructions).
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  struct_wb_ext      wb_WB,
  input  logic [REG_AW-1:0] wb_Rd,
  input  logic [DATA_W-1:0] wb_ALU_result,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_pc_plus4,
  output logic [DATA_W-1:0] id_write_data,
  output logic [REG_AW-1:0] id_write_reg,
  output logic              id_reg_write,
  input  logic              id_wr_ready,
  input  logic [REG_AW-1:0] byp_rs,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam logic [REG_AW-1:0] ZERO_REG = '1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; only the control state below is reset
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [REG_AW-1:0] rd_q   [DEPTH];

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              not_empty;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] wr_value;
  logic [PTR_W-1:0]  byp_idx;

  wb_load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .raw       (wb_read_data),
    .ld_size   (wb_WB.ld_size),
    .ld_signed (wb_WB.ld_signed),
    .ext       (load_ext)
  );

  // Handshake: ready depends only on the registered count
  assign not_empty = (count_q != '0);
  assign wb_ready  = (count_q < FULL_CNT);
  assign accept    = wb_valid && wb_ready;
  assign push      = accept && wb_WB.reg_write && (wb_Rd != ZERO_REG);
  assign pop       = not_empty && id_wr_ready;

  // Writeback value priority: link, then load, then ALU
  always_comb begin
    if (wb_WB.link) begin
      wr_value = wb_pc_plus4;
    end else if (wb_WB.mem_to_reg) begin
      wr_value = load_ext;
    end else begin
      wr_value = wb_ALU_result;
    end
  end

  // Pointer, valid and occupancy next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset; reset drops every pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload write at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= wr_value;
      rd_q[tail_q]   <= wb_Rd;
    end
  end

  // Register-file port shows the head entry, forced to zero when empty
  always_comb begin
    id_reg_write  = not_empty;
    id_write_reg  = '0;
    id_write_data = '0;
    if (not_empty) begin
      id_write_reg  = rd_q[head_q];
      id_write_data = data_q[head_q];
    end
  end

  // Bypass: walk oldest to youngest so the youngest match wins
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = head_q + PTR_W'(i);
      if (valid_q[byp_idx] && (rd_q[byp_idx] == byp_rs) && (byp_rs != ZERO_REG)) begin
        byp_hit  = 1'b1;
        byp_data = data_q[byp_idx];
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Counts every accepted instruction, writing or not; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (accept) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue (default parameters).
// Optional feature macro: WB_RETIRE_CNT_EN (retire counter checks).
module tb_wb_commit_queue;
  import wb_commit_queue_pkg::*;

  logic         clk;
  logic         rst;
  logic         wb_valid;
  logic         wb_ready;
  struct_wb_ext wb_WB;
  logic [4:0]   wb_Rd;
  logic [63:0]  wb_ALU_result;
  logic [63:0]  wb_read_data;
  logic [63:0]  wb_pc_plus4;
  logic [63:0]  id_write_data;
  logic [4:0]   id_write_reg;
  logic         id_reg_write;
  logic         id_wr_ready;
  logic [4:0]   byp_rs;
  logic         byp_hit;
  logic [63:0]  byp_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]  retire_cnt;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks;
  int          errors;
  logic [63:0] acc_cnt;
  logic        mon_en;

  wb_commit_queue #(
    .DATA_W (64),
    .REG_AW (5),
    .DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_WB         (wb_WB),
    .wb_Rd         (wb_Rd),
    .wb_ALU_result (wb_ALU_result),
    .wb_read_data  (wb_read_data),
    .wb_pc_plus4   (wb_pc_plus4),
    .id_write_data (id_write_data),
    .id_write_reg  (id_write_reg),
    .id_reg_write  (id_reg_write),
    .id_wr_ready   (id_wr_ready),
    .byp_rs        (byp_rs),
    .byp_hit       (byp_hit),
    .byp_data      (byp_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt    (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout reached with %0d pending", sb.size());
    $fatal(1, "timeout");
  end

  function automatic struct_wb_ext mk(input logic rw, input logic m2r, input logic lnk,
                                      input logic [1:0] sz, input logic sgn);
    struct_wb_ext c;
    c.reg_write  = rw;
    c.mem_to_reg = m2r;
    c.link       = lnk;
    c.ld_size    = sz;
    c.ld_signed  = sgn;
    return c;
  endfunction

  function automatic logic [63:0] model_val(input struct_wb_ext c, input logic [63:0] alu,
                                            input logic [63:0] rdata, input logic [63:0] pc4);
    logic [63:0] e;
    case (c.ld_size)
      2'd0:    e = {{56{c.ld_signed & rdata[7]}}, rdata[7:0]};
      2'd1:    e = {{48{c.ld_signed & rdata[15]}}, rdata[15:0]};
      2'd2:    e = {{32{c.ld_signed & rdata[31]}}, rdata[31:0]};
      default: e = rdata;
    endcase
    if (c.link) return pc4;
    if (c.mem_to_reg) return e;
    return alu;
  endfunction

  // One instruction offered for one cycle; scoreboarded only if accepted
  task automatic send(input logic [4:0] rd, input struct_wb_ext c, input logic [63:0] alu,
                      input logic [63:0] rdata, input logic [63:0] pc4);
    logic acc;
    wb_valid      = 1'b1;
    wb_Rd         = rd;
    wb_WB         = c;
    wb_ALU_result = alu;
    wb_read_data  = rdata;
    wb_pc_plus4   = pc4;
    acc           = wb_ready;
    @(posedge clk);
    if (acc) begin
      acc_cnt = acc_cnt + 64'd1;
      if (c.reg_write && rd != 5'd31) sb.push_back('{rd: rd, data: model_val(c, alu, rdata, pc4)});
    end
    #1 wb_valid = 1'b0;
  endtask

  // Register-file side monitor: every write must match the oldest expected entry
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (id_reg_write && id_wr_ready) begin
        wr_t exp;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got rd=%0d data=%h, required no write",
                   id_write_reg, id_write_data);
        end else begin
          exp = sb.pop_front();
          if (id_write_reg !== exp.rd || id_write_data !== exp.data) begin
            errors++;
            $display("FAIL write_order got rd=%0d data=%h, required rd=%0d data=%h",
                     id_write_reg, id_write_data, exp.rd, exp.data);
          end
        end
      end else if (!id_reg_write) begin
        checks++;
        if (id_write_reg !== 5'd0 || id_write_data !== 64'd0) begin
          errors++;
          $display("FAIL idle_zero got rd=%0d data=%h, required 0/0", id_write_reg, id_write_data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; wb_valid = 1'b0; wb_WB = '0; wb_Rd = '0; wb_ALU_result = '0;
    wb_read_data = '0; wb_pc_plus4 = '0; id_wr_ready = 1'b0; byp_rs = 5'd0;
    acc_cnt = '0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (wb_ready !== 1'b1 || id_reg_write !== 1'b0 || id_write_data !== 64'd0 ||
        id_write_reg !== 5'd0 || byp_hit !== 1'b0 || byp_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b we=%b rd=%0d d=%h hit=%b bd=%h, required 1 0 0 0 0 0",
               wb_ready, id_reg_write, id_write_reg, id_write_data, byp_hit, byp_data);
    end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_retire got %0d, required 0", retire_cnt);
    end
`endif
    mon_en = 1'b1;
  endtask

  task automatic test_single_write();
    id_wr_ready = 1'b1;
    send(5'd3, mk(1, 0, 0, LD_B, 0), 64'h1234, 64'hdead, 64'h8);
    checks++;
    if (id_reg_write !== 1'b1 || id_write_reg !== 5'd3 || id_write_data !== 64'h1234) begin
      errors++;
      $display("FAIL single_write got we=%b rd=%0d d=%h, required 1 3 1234",
               id_reg_write, id_write_reg, id_write_data);
    end
    @(posedge clk); #1;
    checks++;
    if (id_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL single_write_pop got we=%b, required 0", id_reg_write);
    end
  endtask

  task automatic test_load_ext();
    id_wr_ready = 1'b1;
    send(5'd5, mk(1, 1, 0, LD_B, 1), 64'h1, 64'h80, 64'h0);
    checks++;
    if (id_write_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++;
      $display("FAIL load_sb got %h, required ffffffffffffff80", id_write_data);
    end
    send(5'd5, mk(1, 1, 0, LD_B, 0), 64'h1, 64'h80, 64'h0);
    checks++;
    if (id_write_data !== 64'h80) begin
      errors++;
      $display("FAIL load_ub got %h, required 80", id_write_data);
    end
    send(5'd6, mk(1, 1, 0, LD_H, 1), 64'h1, 64'h1234_8001, 64'h0);
    send(5'd6, mk(1, 1, 0, LD_W, 1), 64'h1, 64'h5_8000_0002, 64'h0);
    send(5'd6, mk(1, 1, 0, LD_W, 0), 64'h1, 64'h5_8000_0002, 64'h0);
    send(5'd6, mk(1, 1, 0, LD_D, 1), 64'h1, 64'h8765_4321_0FED_CBA9, 64'h0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL load_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_pressure();
    id_wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(5'(i), mk(1, 0, 0, LD_B, 0), 64'(i * 16 + 1), 64'h0, 64'h0);
    end
    checks++;
    if (wb_ready !== 1'b0 || id_write_reg !== 5'd1) begin
      errors++;
      $display("FAIL full_ready got rdy=%b head=%0d, required 0 1", wb_ready, id_write_reg);
    end
    send(5'd9, mk(1, 0, 0, LD_B, 0), 64'h99, 64'h0, 64'h0);
    id_wr_ready = 1'b1;
    #1;
    checks++;
    if (wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ready got %b, required 0", wb_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_ready !== 1'b1 || id_write_reg !== 5'd2) begin
      errors++;
      $display("FAIL after_pop got rdy=%b head=%0d, required 1 2", wb_ready, id_write_reg);
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || id_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %0d pending we=%b, required 0 0", sb.size(), id_reg_write);
    end
  endtask

  task automatic test_bypass();
    id_wr_ready = 1'b0;
    send(5'd7, mk(1, 0, 0, LD_B, 0), 64'hA, 64'h0, 64'h0);
    send(5'd7, mk(1, 0, 0, LD_B, 0), 64'hB, 64'h0, 64'h0);
    byp_rs = 5'd7;
    #1;
    checks++;
    if (byp_hit !== 1'b1 || byp_data !== 64'hB) begin
      errors++;
      $display("FAIL byp_youngest got hit=%b d=%h, required 1 b", byp_hit, byp_data);
    end
    // Instruction being accepted must not be visible yet
    wb_valid = 1'b1; wb_Rd = 5'd7; wb_WB = mk(1, 0, 0, LD_B, 0); wb_ALU_result = 64'hC;
    #1;
    checks++;
    if (byp_data !== 64'hB) begin
      errors++;
      $display("FAIL byp_same_cycle got %h, required b", byp_data);
    end
    @(posedge clk);
    acc_cnt = acc_cnt + 64'd1;
    sb.push_back('{rd: 5'd7, data: 64'hC});
    #1 wb_valid = 1'b0;
    #1;
    checks++;
    if (byp_hit !== 1'b1 || byp_data !== 64'hC) begin
      errors++;
      $display("FAIL byp_next_cycle got hit=%b d=%h, required 1 c", byp_hit, byp_data);
    end
    byp_rs = 5'd31;
    #1;
    checks++;
    if (byp_hit !== 1'b0 || byp_data !== 64'd0) begin
      errors++;
      $display("FAIL byp_zero_reg got hit=%b d=%h, required 0 0", byp_hit, byp_data);
    end
    byp_rs = 5'd2;
    #1;
    checks++;
    if (byp_hit !== 1'b0 || byp_data !== 64'd0) begin
      errors++;
      $display("FAIL byp_miss got hit=%b d=%h, required 0 0", byp_hit, byp_data);
    end
    id_wr_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || byp_hit !== 1'b0) begin
      errors++;
      $display("FAIL byp_drain got %0d pending hit=%b, required 0 0", sb.size(), byp_hit);
    end
  endtask

  task automatic test_zero_link();
    id_wr_ready = 1'b1;
    send(5'd31, mk(1, 0, 0, LD_B, 0), 64'h55, 64'h0, 64'h0);
    checks++;
    if (id_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg got we=%b, required 0", id_reg_write);
    end
    send(5'd4, mk(0, 0, 0, LD_B, 0), 64'h66, 64'h0, 64'h0);
    checks++;
    if (id_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL no_write got we=%b, required 0", id_reg_write);
    end
    send(5'd30, mk(1, 1, 1, LD_B, 1), 64'h77, 64'hFF, 64'h404);
    checks++;
    if (id_reg_write !== 1'b1 || id_write_reg !== 5'd30 || id_write_data !== 64'h404) begin
      errors++;
      $display("FAIL link got we=%b rd=%0d d=%h, required 1 30 404",
               id_reg_write, id_write_reg, id_write_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic        exp_hit;
    logic [63:0] exp_data;
    for (int n = 0; n < 400; n++) begin
      id_wr_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        rd = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
        send(rd, mk($urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      end else begin
        @(posedge clk); #1;
      end
      rs = ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
      byp_rs = rs;
      #1;
      exp_hit  = 1'b0;
      exp_data = 64'd0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].rd == rs) begin
          exp_hit  = 1'b1;
          exp_data = sb[i].data;
          break;
        end
      end
      checks++;
      if (byp_hit !== exp_hit || byp_data !== exp_data ||
          wb_ready !== (sb.size() < 4)) begin
        errors++;
        $display("FAIL rand_bypass rs=%0d got hit=%b d=%h rdy=%b, required %b %h %b",
                 rs, byp_hit, byp_data, wb_ready, exp_hit, exp_data, sb.size() < 4);
      end
    end
    id_wr_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got %0d pending, required 0", sb.size());
    end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== acc_cnt) begin
      errors++;
      $display("FAIL retire_cnt got %0d, required %0d", retire_cnt, acc_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    id_wr_ready = 1'b0;
    send(5'd10, mk(1, 0, 0, LD_B, 0), 64'h10, 64'h0, 64'h0);
    send(5'd11, mk(1, 0, 0, LD_B, 0), 64'h11, 64'h0, 64'h0);
    send(5'd12, mk(1, 0, 0, LD_B, 0), 64'h12, 64'h0, 64'h0);
    byp_rs = 5'd11;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    acc_cnt = '0;
    checks++;
    if (id_reg_write !== 1'b0 || byp_hit !== 1'b0 || wb_ready !== 1'b1 ||
        id_write_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid got we=%b hit=%b rdy=%b d=%h, required 0 0 1 0",
               id_reg_write, byp_hit, wb_ready, id_write_data);
    end
`ifdef WB_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_retire got %0d, required 0", retire_cnt);
    end
`endif
    id_wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (id_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stale got we=%b, required 0", id_reg_write);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_load_ext();
    test_back_pressure();
    test_bypass();
    test_zero_link();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
